// File: rtl/filtez_core.sv
// ---------------------------------------------------------------------------
// filtez_core -- ADPCM zero-section predictor filter.
//
// On ap_start the block reads TAPS entries from the bli (coefficient) and
// dlti (delay-line) memories and accumulates sum(bli[i] * dlti[i]) in a
// 2*DATA_W-bit signed accumulator that wraps modulo 2^(2*DATA_W). The
// accumulator, arithmetic-shifted right by SHIFT and truncated to DATA_W bits,
// is registered onto ap_return when the run completes.
//
// Ports:
//   ap_clk         clock, all state on rising edge
//   ap_rst_n       asynchronous active-low reset
//   ap_start       start request, sampled in IDLE only
//   ap_done        one-cycle pulse, ap_return valid from the next cycle
//   ap_idle        block idle and not being started
//   ap_ready       one-cycle pulse, coincident with ap_done
//   bli_address0   coefficient read address
//   bli_ce0        coefficient read enable
//   bli_q0         coefficient read data, 1-cycle latency
//   dlti_address0  delay-line read address
//   dlti_ce0       delay-line read enable
//   dlti_q0        delay-line read data, 1-cycle latency
//   ap_return      filter result, held until the next completion
// ---------------------------------------------------------------------------
module filtez_core #(
  parameter int TAPS   = 6,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 14
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [ADDR_W-1:0] bli_address0,
  output logic              bli_ce0,
  input  logic [DATA_W-1:0] bli_q0,
  output logic [ADDR_W-1:0] dlti_address0,
  output logic              dlti_ce0,
  input  logic [DATA_W-1:0] dlti_q0,
  output logic [DATA_W-1:0] ap_return
);

  localparam int                ACC_W    = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic                     valid_q, valid_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        ret_q, ret_d;

  // Both operands are sign-extended to the accumulator width so the product
  // is the full signed 2*DATA_W-bit result.
  logic signed [ACC_W-1:0]  bli_ext, dlti_ext, prod;

  assign bli_ext  = {{DATA_W{bli_q0[DATA_W-1]}}, bli_q0};
  assign dlti_ext = {{DATA_W{dlti_q0[DATA_W-1]}}, dlti_q0};
  assign prod     = bli_ext * dlti_ext;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      acc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
      ret_q   <= ret_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    valid_d       = valid_q;
    acc_d         = acc_q;
    ret_d         = ret_q;
    ap_done       = 1'b0;
    ap_ready      = 1'b0;
    ap_idle       = 1'b0;
    bli_ce0       = 1'b0;
    dlti_ce0      = 1'b0;
    bli_address0  = '0;
    dlti_address0 = '0;

    unique case (state_q)
      S_IDLE: begin
        ap_idle = !ap_start;
        if (ap_start) begin
          acc_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        bli_ce0       = 1'b1;
        dlti_ce0      = 1'b1;
        bli_address0  = idx_q;
        dlti_address0 = idx_q;
        // Read data lags the address by one cycle; valid_q marks that the
        // q0 inputs currently hold the previous tap.
        if (valid_q) begin
          acc_d = acc_q + prod;
        end
        valid_d = 1'b1;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Last tap's data arrives here; memories hold q0 with ce0 low.
        acc_d   = acc_q + prod;
        state_d = S_DONE;
      end

      S_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        ret_d    = acc_q[SHIFT+DATA_W-1:SHIFT];
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ap_return = ret_q;

endmodule

// File: tb/tb_filtez_core.sv
// ---------------------------------------------------------------------------
// tb_filtez_core -- directed self-checking bench for filtez_core.
// Models the two 1-cycle-latency ROMs, drives directed coefficient/delay-line
// vectors with hand-computed results and checks handshake timing, address
// sequencing, arithmetic and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_filtez_core;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [2:0]  bli_address0;
  logic        bli_ce0;
  logic [31:0] bli_q0;
  logic [2:0]  dlti_address0;
  logic        dlti_ce0;
  logic [31:0] dlti_q0;
  logic [31:0] ap_return;

  logic [31:0] bli_mem  [8];
  logic [31:0] dlti_mem [8];

  int checks;
  int errors;

  filtez_core dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .bli_address0  (bli_address0),
    .bli_ce0       (bli_ce0),
    .bli_q0        (bli_q0),
    .dlti_address0 (dlti_address0),
    .dlti_ce0      (dlti_ce0),
    .dlti_q0       (dlti_q0),
    .ap_return     (ap_return)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Single-port ROM models: data registered one cycle after the address,
  // held while ce0 is low.
  always @(posedge ap_clk) begin
    if (bli_ce0)  bli_q0  <= bli_mem[bli_address0];
    if (dlti_ce0) dlti_q0 <= dlti_mem[dlti_address0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 8; i++) begin
      bli_mem[i]  = 32'd0;
      dlti_mem[i] = 32'd0;
    end
  endtask

  // One invocation with ap_start pulsed for a single cycle. Checks the done
  // latency (T+8), ce0 count, the result, and idle after completion.
  task automatic run_op(input string tag, input logic [31:0] exp);
    int done_at;
    int ce_cnt;
    int ready_ok;
    done_at  = 0;
    ce_cnt   = 0;
    ready_ok = 0;
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(posedge ap_clk);   // cycle T ends here
    #1 ap_start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge ap_clk);  // now in cycle T+n
      if (bli_ce0) ce_cnt++;
      if (ap_done) begin
        done_at  = n;
        ready_ok = ap_ready ? 1 : 0;
        break;
      end
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'd8);
    check({tag, "_ready_with_done"}, 64'(ready_ok), 64'd1);
    check({tag, "_ce_cycles"}, 64'(ce_cnt), 64'd6);
    @(negedge ap_clk);    // T+9
    check({tag, "_result"}, 64'(ap_return), 64'(exp));
    check({tag, "_done_low_after"}, 64'(ap_done), 64'd0);
    check({tag, "_idle_after"}, 64'(ap_idle), 64'd1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ap_start = 1'b0;
    ap_rst_n = 1'b0;
    clear_mems();
    repeat (3) @(negedge ap_clk);

    // Reset state.
    check("rst_idle", 64'(ap_idle), 64'd1);
    check("rst_done", 64'(ap_done), 64'd0);
    check("rst_ready", 64'(ap_ready), 64'd0);
    check("rst_ce", 64'({bli_ce0, dlti_ce0}), 64'd0);
    check("rst_addr", 64'({bli_address0, dlti_address0}), 64'd0);
    check("rst_return", 64'(ap_return), 64'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // 1: all coefficients zero, delay line arbitrary.
    for (int i = 0; i < 6; i++) dlti_mem[i] = 32'h1234_0000 + 32'(i * 977);
    run_op("zero_coef", 32'h0000_0000);

    // 2: bli=16384, dlti=1..6 -> 16384*21 >> 14 = 21.
    for (int i = 0; i < 6; i++) begin
      bli_mem[i]  = 32'd16384;
      dlti_mem[i] = 32'(i + 1);
    end
    run_op("ramp", 32'h0000_0015);

    // 3a: -1 * 1 = -1, floor(-1/16384) = -1.
    clear_mems();
    bli_mem[0]  = 32'hFFFF_FFFF;
    dlti_mem[0] = 32'd1;
    run_op("neg_one", 32'hFFFF_FFFF);

    // 3b: -32768 * 3 = -98304 -> -6.
    bli_mem[0]  = 32'hFFFF_8000;
    dlti_mem[0] = 32'd3;
    run_op("neg_six", 32'hFFFF_FFFA);

    // Zero result after a non-zero one: ap_return must reload, not hold.
    clear_mems();
    dlti_mem[2] = 32'd55;
    run_op("zero_reload", 32'h0000_0000);

    // 4: 2*(2^31-1)^2 = 2^63-2^33+2; >>14 low 32 bits = 0xFFF80000.
    bli_mem[0]  = 32'h7FFF_FFFF;
    bli_mem[1]  = 32'h7FFF_FFFF;
    dlti_mem[0] = 32'h7FFF_FFFF;
    dlti_mem[1] = 32'h7FFF_FFFF;
    run_op("wide_acc", 32'hFFF8_0000);

    // Last tap only: exercises the drain-cycle accumulate.
    clear_mems();
    bli_mem[5]  = 32'd32768;
    dlti_mem[5] = 32'd7;
    run_op("last_tap", 32'h0000_000E);

    // 5: protocol, addresses 0..5 on T+1..T+6, start held -> second done T+17.
    clear_mems();
    for (int i = 0; i < 6; i++) begin
      bli_mem[i]  = 32'd16384;
      dlti_mem[i] = 32'(i + 1);
    end
    begin
      int ce_first;
      int ce_total;
      int done_cnt;
      int first_done;
      int second_done;
      int addr_err;
      int hold_err;
      ce_first    = 0;
      ce_total    = 0;
      done_cnt    = 0;
      first_done  = 0;
      second_done = 0;
      addr_err    = 0;
      hold_err    = 0;
      @(negedge ap_clk);
      ap_start = 1'b1;
      @(posedge ap_clk);
      for (int n = 1; n <= 19; n++) begin
        @(negedge ap_clk);
        if (n <= 6) begin
          if (bli_address0 !== 3'(n - 1) || dlti_address0 !== 3'(n - 1)) addr_err++;
          if (!bli_ce0 || !dlti_ce0) addr_err++;
        end
        if (bli_ce0 || dlti_ce0) begin
          if (n <= 8) ce_first++;
          ce_total++;
        end
        if (n == 9) check("b2b_idle_low_while_start", 64'(ap_idle), 64'd0);
        if (n == 10) ap_start = 1'b0;
        if (n >= 9 && n <= 16 && ap_return !== 32'd21) hold_err++;
        if (ap_done) begin
          done_cnt++;
          if (first_done == 0) first_done = n;
          else second_done = n;
        end
      end
      check("b2b_addr_seq", 64'(addr_err), 64'd0);
      check("b2b_ce_first_run", 64'(ce_first), 64'd6);
      check("b2b_ce_total", 64'(ce_total), 64'd12);
      check("b2b_done_count", 64'(done_cnt), 64'd2);
      check("b2b_first_done", 64'(first_done), 64'd8);
      check("b2b_second_done", 64'(second_done), 64'd17);
      check("b2b_return_hold", 64'(hold_err), 64'd0);
      check("b2b_second_result", 64'(ap_return), 64'd21);
    end

    // 6: reset asserted mid-run at T+4, outputs clear without a clock edge.
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    repeat (4) @(negedge ap_clk);   // cycle T+4
    check("mid_rst_ce_before", 64'(bli_ce0), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_ce", 64'({bli_ce0, dlti_ce0}), 64'd0);
    check("mid_rst_done", 64'(ap_done), 64'd0);
    check("mid_rst_return", 64'(ap_return), 64'd0);
    check("mid_rst_idle", 64'(ap_idle), 64'd1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    run_op("after_rst", 32'h0000_0015);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
